// File: rtl/wb_slave_mem_responder_pkg.sv
// Shared types and helpers for the Wishbone memory responder.
package wb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W  = 16;   // statistics counter width
    localparam int WAIT_W = 4;    // wait-state configuration width

    // Saturating increment for statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // An out-of-range access terminates with ERR only when error reporting is on;
    // otherwise it is ACKed and the index wraps.
    function automatic logic term_is_err(input logic oor, input logic err_en);
        return oor && err_en;
    endfunction

endpackage

// File: rtl/wb_slave_mem_responder_if.sv
// Wishbone classic-cycle bus between a master and the memory responder.
interface wb_slave_mem_responder_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   wb_adr_i;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic                    wb_we_i;
    logic [SELECT_WIDTH-1:0] wb_sel_i;
    logic                    wb_stb_i;
    logic                    wb_cyc_i;
    logic                    wb_ack_o;
    logic                    wb_err_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_slave_mem_responder_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module wb_slave_ram #(
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH        = 256,
    parameter int IDX_W        = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    we,
    input  logic [SELECT_WIDTH-1:0] sel,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane writes and read-before-write registered read at the same index.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < SELECT_WIDTH; b++) begin
                if (sel[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        rdata <= mem[idx];
    end
endmodule

// File: rtl/wb_slave_mem_responder.sv
// Wishbone classic-cycle slave backed by a byte-enabled RAM. Each strobe gets exactly
// one ACK or ERR after cfg_wait_i wait states; read/write/error counts are kept.
module wb_slave_mem_responder
    import wb_slave_pkg::*;
#(
    parameter int                  DATA_WIDTH   = 32,
    parameter int                  ADDR_WIDTH   = 32,
    parameter int                  SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int                  MEM_DEPTH    = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter bit                  ERR_ENABLE   = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    wb_slave_mem_responder_if.slave wb,
    input  logic [WAIT_W-1:0]  cfg_wait_i,
    output logic [CNT_W-1:0]   stat_rd_cnt,
    output logic [CNT_W-1:0]   stat_wr_cnt,
    output logic [CNT_W-1:0]   stat_err_cnt
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int OFS_W = $clog2(SELECT_WIDTH);

    state_t                  state;
    logic [WAIT_W-1:0]       cnt;
    logic [IDX_W-1:0]        lat_idx;
    logic                    lat_we;
    logic                    lat_oor;
    logic [SELECT_WIDTH-1:0] lat_sel;
    logic [DATA_WIDTH-1:0]   lat_dat;
    logic                    ack_q;
    logic                    err_q;

    logic [ADDR_WIDTH-1:0]   ofs;
    logic [ADDR_WIDTH-1:0]   word;
    logic [IDX_W-1:0]        req_idx;
    logic                    req_oor;
    logic                    req;

    logic [IDX_W-1:0]        ram_idx;
    logic                    ram_we;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    // Word index and range check of the address currently on the bus.
    always_comb begin
        ofs     = wb.wb_adr_i - BASE_ADDR;
        word    = ofs >> OFS_W;
        req_idx = word[IDX_W-1:0];
        req_oor = (wb.wb_adr_i < BASE_ADDR) || ((word >> IDX_W) != '0);
        req     = wb.wb_cyc_i && wb.wb_stb_i;
    end

    // The RAM read is issued one cycle ahead of RESP: from the bus when leaving IDLE
    // straight to RESP, from the latched index otherwise. Writes land at the RESP edge.
    assign ram_idx = (state == IDLE) ? req_idx : lat_idx;
    assign ram_we  = ack_q && lat_we;

    wb_slave_ram #(
        .DATA_WIDTH   (DATA_WIDTH),
        .SELECT_WIDTH (SELECT_WIDTH),
        .DEPTH        (MEM_DEPTH),
        .IDX_W        (IDX_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .sel   (lat_sel),
        .idx   (ram_idx),
        .wdata (lat_dat),
        .rdata (ram_rdata)
    );

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = (ack_q && !lat_we) ? ram_rdata : '0;

    // Transfer FSM: latch request, count wait states, emit one termination, update stats.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_idx      <= '0;
            lat_we       <= 1'b0;
            lat_oor      <= 1'b0;
            lat_sel      <= '0;
            lat_dat      <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            stat_rd_cnt  <= '0;
            stat_wr_cnt  <= '0;
            stat_err_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_idx <= req_idx;
                        lat_we  <= wb.wb_we_i;
                        lat_oor <= req_oor;
                        lat_sel <= wb.wb_sel_i;
                        lat_dat <= wb.wb_dat_i;
                        cnt     <= cfg_wait_i;
                        if (cfg_wait_i == '0) begin
                            state <= RESP;
                            ack_q <= !term_is_err(req_oor, ERR_ENABLE);
                            err_q <= term_is_err(req_oor, ERR_ENABLE);
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - WAIT_W'(1);
                        if (cnt == WAIT_W'(1)) begin
                            state <= RESP;
                            ack_q <= !term_is_err(lat_oor, ERR_ENABLE);
                            err_q <= term_is_err(lat_oor, ERR_ENABLE);
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (ack_q) begin
                        if (lat_we) stat_wr_cnt <= sat_inc(stat_wr_cnt);
                        else        stat_rd_cnt <= sat_inc(stat_rd_cnt);
                    end
                    if (err_q) stat_err_cnt <= sat_inc(stat_err_cnt);
                end
                default: begin
                    state <= IDLE;
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_slave_mem_responder.sv
// Directed bench for the Wishbone memory responder with a scoreboard of expected terminations.
module tb_wb_slave_mem_responder;
    import wb_slave_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cfg_wait_i = 4'd0;
    logic [15:0] stat_rd_cnt, stat_wr_cnt, stat_err_cnt;

    wb_slave_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) wb_bus ();

    wb_slave_mem_responder #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .SELECT_WIDTH (4),
        .MEM_DEPTH    (256),
        .BASE_ADDR    (32'h0000_0000),
        .ERR_ENABLE   (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wb           (wb_bus.slave),
        .cfg_wait_i   (cfg_wait_i),
        .stat_rd_cnt  (stat_rd_cnt),
        .stat_wr_cnt  (stat_wr_cnt),
        .stat_err_cnt (stat_err_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_err;
        logic        is_rd;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [256];
    int          n_checks = 0;
    int          n_err    = 0;
    bit          mon_en   = 1'b0;
    int          exp_rd = 0, exp_wr = 0, exp_err = 0;
    logic [31:0] last_rd = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_rd_cnt"},  32'(stat_rd_cnt),  32'(exp_rd));
        check({tag, "_wr_cnt"},  32'(stat_wr_cnt),  32'(exp_wr));
        check({tag, "_err_cnt"}, 32'(stat_err_cnt), 32'(exp_err));
    endtask

    // Queue one expected termination and update the reference memory and counters.
    task automatic expect_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                               input logic [3:0] sel);
        exp_t       e;
        logic [7:0] mi;
        logic       oor;
        mi       = adr[9:2];
        oor      = (adr >> 2) >= 32'd256;
        e.is_err = oor;
        e.is_rd  = !we;
        e.dat    = oor ? 32'h0 : model[mi];
        sb.push_back(e);
        if (!oor && we) begin
            for (int b = 0; b < 4; b++) if (sel[b]) model[mi][b*8 +: 8] = dat[b*8 +: 8];
        end
        if (oor)     exp_err++;
        else if (we) exp_wr++;
        else         exp_rd++;
    endtask

    task automatic drive(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel);
        wb_bus.wb_adr_i = adr;
        wb_bus.wb_we_i  = we;
        wb_bus.wb_dat_i = dat;
        wb_bus.wb_sel_i = sel;
        wb_bus.wb_cyc_i = 1'b1;
        wb_bus.wb_stb_i = 1'b1;
    endtask

    task automatic release_bus();
        wb_bus.wb_cyc_i = 1'b0;
        wb_bus.wb_stb_i = 1'b0;
        wb_bus.wb_we_i  = 1'b0;
    endtask

    // One complete transfer: checks latency, then that the termination is a single pulse.
    // cfg_wait_i is scrambled after the first edge; the DUT must ignore it mid-transfer.
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [3:0] wt);
        int cyc_n;
        expect_xfer(adr, we, dat, sel);
        cfg_wait_i = wt;
        drive(adr, we, dat, sel);
        cyc_n = 0;
        do begin
            @(posedge clock); #1;
            cyc_n++;
            if (cyc_n == 1) cfg_wait_i = ~wt;
        end while (!(wb_bus.wb_ack_o || wb_bus.wb_err_o) && cyc_n < 40);
        check("latency", 32'(cyc_n), 32'(wt) + 32'd1);
        release_bus();
        @(posedge clock); #1;
        check("single_pulse", {30'd0, wb_bus.wb_ack_o, wb_bus.wb_err_o}, 32'd0);
    endtask

    // Scoreboard consumer: every termination must match the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            if (wb_bus.wb_ack_o || wb_bus.wb_err_o) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $error("FAIL unexpected_term: observed ack=%0b err=%0b expected no termination",
                           wb_bus.wb_ack_o, wb_bus.wb_err_o);
                end else begin
                    e = sb.pop_front();
                    check("term_err", 32'(wb_bus.wb_err_o), 32'(e.is_err));
                    check("term_ack", 32'(wb_bus.wb_ack_o), 32'(!e.is_err));
                    check("term_dat", wb_bus.wb_dat_o, (e.is_rd && !e.is_err) ? e.dat : 32'h0);
                    if (e.is_rd) last_rd = wb_bus.wb_dat_o;
                end
            end else begin
                check("idle_dat", wb_bus.wb_dat_o, 32'h0);
            end
        end
    end

    initial begin
        logic [4:0] pat;
        wb_bus.wb_adr_i = '0;
        wb_bus.wb_dat_i = '0;
        wb_bus.wb_sel_i = '0;
        release_bus();

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("rst_ack", 32'(wb_bus.wb_ack_o), 32'd0);
        check("rst_err", 32'(wb_bus.wb_err_o), 32'd0);
        check("rst_dat", wb_bus.wb_dat_o, 32'h0);
        check_stats("rst");
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        mon_en = 1'b1;
        @(posedge clock); #1;

        // 1: zero-wait write then read
        xfer(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 4'd0);
        xfer(32'h10, 1'b0, 32'h0, 4'hF, 4'd0);
        check("t1_readback", last_rd, 32'hDEAD_BEEF);
        check_stats("t1");

        // 2: partial-lane write with three wait states, then a sel=0 write
        xfer(32'h20, 1'b1, 32'h0, 4'hF, 4'd0);
        xfer(32'h20, 1'b1, 32'h1122_3344, 4'b0101, 4'd3);
        xfer(32'h20, 1'b0, 32'h0, 4'hF, 4'd0);
        check("t2_readback", last_rd, 32'h0022_0044);
        xfer(32'h20, 1'b1, 32'hFFFF_FFFF, 4'b0000, 4'd1);
        xfer(32'h20, 1'b0, 32'h0, 4'h0, 4'd2);
        check("t2_sel0", last_rd, 32'h0022_0044);

        // 3: out-of-range read and write terminate with ERR and touch nothing
        xfer(32'h0, 1'b1, 32'h0, 4'hF, 4'd0);
        xfer(32'h400, 1'b0, 32'h0, 4'hF, 4'd2);
        check_stats("t3_rd");
        xfer(32'h400, 1'b1, 32'hFFFF_FFFF, 4'hF, 4'd0);
        xfer(32'h0, 1'b0, 32'h0, 4'hF, 4'd0);
        check("t3_ram0", last_rd, 32'h0);
        check_stats("t3");

        // 4: aborted write in WAIT leaves RAM and counters alone
        xfer(32'h8, 1'b1, 32'hA5A5_5A5A, 4'hF, 4'd0);
        cfg_wait_i = 4'd5;
        drive(32'h8, 1'b1, 32'hFFFF_FFFF, 4'hF);
        repeat (2) @(posedge clock);
        #1 wb_bus.wb_cyc_i = 1'b0;
        repeat (8) @(posedge clock);
        #1 release_bus();
        @(posedge clock); #1;
        check_stats("t4_abort");
        xfer(32'h8, 1'b0, 32'h0, 4'hF, 4'd0);
        check("t4_ram2", last_rd, 32'hA5A5_5A5A);

        // 5: strobe held for three back-to-back reads
        for (int i = 0; i < 3; i++) expect_xfer(32'h10, 1'b0, 32'h0, 4'hF);
        cfg_wait_i = 4'd0;
        drive(32'h10, 1'b0, 32'h0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            pat[4-i] = wb_bus.wb_ack_o;
        end
        release_bus();
        @(posedge clock); #1;
        check("t5_pattern", 32'(pat), 32'(5'b10101));
        check("t5_data", last_rd, 32'hDEAD_BEEF);
        check_stats("t5");

        // 6: reset during WAIT drops the write; the next transfer completes normally
        cfg_wait_i = 4'd7;
        drive(32'h10, 1'b1, 32'h0BAD_F00D, 4'hF);
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        exp_rd = 0; exp_wr = 0; exp_err = 0;
        #1;
        check("t6_ack", 32'(wb_bus.wb_ack_o), 32'd0);
        check("t6_err", 32'(wb_bus.wb_err_o), 32'd0);
        check("t6_dat", wb_bus.wb_dat_o, 32'h0);
        check_stats("t6_rst");
        release_bus();
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        xfer(32'h10, 1'b0, 32'h0, 4'hF, 4'd0);
        check("t6_readback", last_rd, 32'hDEAD_BEEF);
        check_stats("t6");

        repeat (2) @(posedge clock);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
